// File: rtl/command_issue_queue_if.sv
// Front-end/separator/execution-unit signal bundle for command_issue_queue.
// master = scheduler/execution-unit side, slave = the queue itself.
interface command_issue_queue_if #(
    parameter int CMD_W = 56,
    parameter int CNT_W = 4
);
    logic [CMD_W-1:0] cmd_in;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] Combined_Command;
    logic             Enable;
    logic             exec_done;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             done_err;

    modport master (
        output cmd_in, cmd_valid, exec_done,
        input  cmd_ready, Combined_Command, Enable, busy, count, done_err
    );

    modport slave (
        input  cmd_in, cmd_valid, exec_done,
        output cmd_ready, Combined_Command, Enable, busy, count, done_err
    );
endinterface

// File: rtl/command_issue_queue.sv
// FIFO of combined PIM commands issued one at a time to the command separator,
// with a one-cycle Enable strobe and a wait for exec_done; opcode-0 entries are dropped.
module command_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CMD_W = 56,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    command_issue_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             enable_q, enable_d;
    logic             done_err_q, done_err_d;

    logic             push_s;
    logic             pop_s;
    logic [CMD_W-1:0] head_s;
    logic             head_nop_s;

    assign head_s     = mem_q[rd_ptr_q];
    assign head_nop_s = (head_s[CMD_W-1 -: 6] == 6'd0);
    // No bypass: readiness depends only on the registered occupancy.
    assign push_s     = bus.cmd_valid && (count_q != DEPTH_C);

    // Next-state, pop decision, FIFO bookkeeping and output registers.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        done_err_d = done_err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        pop_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.exec_done) begin
                    done_err_d = 1'b1;
                end else begin
                    done_err_d = done_err_q;
                end
                if (count_q != ZERO_C) begin
                    pop_s = 1'b1;
                    if (head_nop_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                        cmd_d   = head_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (bus.exec_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.exec_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_s) begin
            mem_d[wr_ptr_q] = bus.cmd_in;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // Registered so that Enable is high exactly while state_q == ISSUE.
        enable_d = (state_d == ISSUE);
    end

    // Control state, pointers, occupancy and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= ZERO_C;
            cmd_q      <= {CMD_W{1'b0}};
            enable_q   <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cmd_q      <= cmd_d;
            enable_q   <= enable_d;
            done_err_q <= done_err_d;
        end
    end

    // Storage array; contents are don't-care after reset since count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.cmd_ready        = (count_q != DEPTH_C);
    assign bus.Combined_Command = cmd_q;
    assign bus.Enable           = enable_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.count            = count_q;
    assign bus.done_err         = done_err_q;
endmodule
